// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C datapath blocks.
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } shift_state_t;

endpackage

// File: rtl/i2c_shift_engine_if.sv
// Bus between the byte/bit controllers (master) and the shift engine (slave).
interface i2c_shift_engine_if
    import i2c_pkg::*;
#(
    parameter int W = I2C_BYTE_W
);
    localparam int CNT_W = $clog2(W + 1);

    logic             clr;
    logic             load;
    logic [W-1:0]     data_load;
    logic             msb_first;
    logic             shift;
    logic             serial_i;
    logic             serial_o;
    logic [W-1:0]     data_o;
    logic [CNT_W-1:0] bit_cnt;
    logic             busy;
    logic             done;

    modport master (
        output clr, load, data_load, msb_first, shift, serial_i,
        input  serial_o, data_o, bit_cnt, busy, done
    );

    modport slave (
        input  clr, load, data_load, msb_first, shift, serial_i,
        output serial_o, data_o, bit_cnt, busy, done
    );

endinterface

// File: rtl/i2c_bit_counter.sv
// Frame bit counter; wrap flags the terminal count W-1 so the next increment closes the frame.
module i2c_bit_counter
    import i2c_pkg::*;
#(
    parameter  int W     = I2C_BYTE_W,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign wrap = (r_cnt == LAST);

endmodule

// File: rtl/i2c_shift_engine.sv
// Serial/parallel shift engine: loads a word, shifts it out while shifting in, self-terminates after W bits.
module i2c_shift_engine
    import i2c_pkg::*;
#(
    parameter int W = I2C_BYTE_W
) (
    input  logic               clk,
    input  logic               rst,
    i2c_shift_engine_if.slave  bus
);

    localparam int CNT_W = $clog2(W + 1);

    shift_state_t     r_state;
    logic [W-1:0]     r_data;
    logic             r_ord;
    logic             r_done;

    logic             w_shift_acc;
    logic             w_cnt_clr;
    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt;

    // A load in the same cycle as shift wins; the shift is neither applied nor counted.
    assign w_shift_acc = (r_state == ACTIVE) && bus.shift && !bus.load && !bus.clr;
    assign w_cnt_clr   = bus.clr || bus.load;

    i2c_bit_counter #(
        .W (W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .inc  (w_shift_acc),
        .cnt  (w_cnt),
        .wrap (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_ord   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.clr) begin
                r_state <= IDLE;
                r_data  <= '0;
                r_ord   <= 1'b1;
            end else if (bus.load) begin
                r_state <= ACTIVE;
                r_data  <= bus.data_load;
                r_ord   <= bus.msb_first;
            end else if (w_shift_acc) begin
                r_data <= r_ord ? {r_data[W-2:0], bus.serial_i}
                                : {bus.serial_i, r_data[W-1:1]};
                if (w_wrap) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.serial_o = r_ord ? r_data[W-1] : r_data[0];
    assign bus.data_o   = r_data;
    assign bus.bit_cnt  = w_cnt;
    assign bus.busy     = (r_state == ACTIVE);
    assign bus.done     = r_done;

endmodule

// File: tb/tb_i2c_shift_engine.sv
// Directed bench for i2c_shift_engine with a word-level reference model checked every cycle.
module tb_i2c_shift_engine;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    i2c_shift_engine_if #(.W(W)) bus ();

    i2c_shift_engine #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int dut_dones = 0;
    bit chk_en    = 1'b0;

    // Reference model: the frame as a word plus a count of bits moved so far.
    int m_word;
    int m_cnt;
    bit m_ord;
    bit m_busy;
    bit m_done;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, req, req, $time);
        end
    endtask

    function automatic int m_serial();
        return m_ord ? ((m_word >> (W - 1)) & 1) : (m_word & 1);
    endfunction

    task automatic model_reset();
        m_word = 0;
        m_cnt  = 0;
        m_ord  = 1'b1;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit l, input int dl, input bit msb, input bit sh, input bit si);
        m_done = 1'b0;
        if (c) begin
            model_reset();
        end else if (l) begin
            m_word = dl & MASK;
            m_ord  = msb;
            m_cnt  = 0;
            m_busy = 1'b1;
        end else if (sh && m_busy) begin
            if (m_ord) m_word = ((m_word << 1) | int'(si)) & MASK;
            else       m_word = (m_word >> 1) | (int'(si) << (W - 1));
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
                m_cnt  = 0;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_data_o",   int'(bus.data_o),   m_word);
            chk("cyc_serial_o", int'(bus.serial_o), m_serial());
            chk("cyc_bit_cnt",  int'(bus.bit_cnt),  m_cnt);
            chk("cyc_busy",     int'(bus.busy),     int'(m_busy));
            chk("cyc_done",     int'(bus.done),     int'(m_done));
            if (bus.done) dut_dones++;
        end
    end

    task automatic cyc(input bit c, input bit l, input logic [W-1:0] dl, input bit msb, input bit sh, input bit si);
        bus.clr       = c;
        bus.load      = l;
        bus.data_load = dl;
        bus.msb_first = msb;
        bus.shift     = sh;
        bus.serial_i  = si;
        @(posedge clk);
        model_step(c, l, int'(dl), msb, sh, si);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    bit so_a5  [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit rx_msb [8] = '{1, 1, 0, 0, 1, 0, 1, 0};
    bit rx_lsb [8] = '{1, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int d0;
        bus.clr       = 1'b0;
        bus.load      = 1'b0;
        bus.data_load = '0;
        bus.msb_first = 1'b0;
        bus.shift     = 1'b0;
        bus.serial_i  = 1'b0;
        model_reset();

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_data_o",   int'(bus.data_o),   0);
        chk("reset_serial_o", int'(bus.serial_o), 0);
        chk("reset_bit_cnt",  int'(bus.bit_cnt),  0);
        chk("reset_busy",     int'(bus.busy),     0);
        chk("reset_done",     int'(bus.done),     0);

        // Shifts before any load are ignored.
        repeat (3) cyc(1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
        chk("idle_data_o",  int'(bus.data_o),  0);
        chk("idle_bit_cnt", int'(bus.bit_cnt), 0);
        chk("idle_busy",    int'(bus.busy),    0);
        chk("idle_dones",   dut_dones,         0);

        // MSB-first frame; msb_first flips mid-frame with no effect.
        cyc(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("msb_serial_o_%0d", i), int'(bus.serial_o), int'(so_a5[i]));
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, rx_msb[i]);
            if (i < 7) chk($sformatf("msb_early_done_%0d", i), int'(bus.done), 0);
        end
        chk("msb_done",    int'(bus.done),    1);
        chk("msb_data_o",  int'(bus.data_o),  8'hCA);
        chk("msb_busy",    int'(bus.busy),    0);
        chk("msb_bit_cnt", int'(bus.bit_cnt), 0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("msb_done_drop", int'(bus.done),   0);
        chk("msb_hold",      int'(bus.data_o), 8'hCA);

        // LSB-first frame.
        cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_serial_o_%0d", i), int'(bus.serial_o), int'(so_a5[i]));
            cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, rx_lsb[i]);
        end
        chk("lsb_done",   int'(bus.done),   1);
        chk("lsb_data_o", int'(bus.data_o), 8'h01);
        idle(1);

        // Load collides with shift at bit_cnt=5: load wins, shift dropped.
        cyc(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("coll_pre_cnt", int'(bus.bit_cnt), 5);
        d0 = dut_dones;
        cyc(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        chk("coll_data_o",  int'(bus.data_o),  8'h3C);
        chk("coll_bit_cnt", int'(bus.bit_cnt), 0);
        chk("coll_busy",    int'(bus.busy),    1);
        chk("coll_done",    int'(bus.done),    0);
        repeat (8) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("coll_dones", dut_dones - d0, 1);
        chk("coll_final", int'(bus.data_o), 0);

        // Shifts with random idle gaps.
        d0 = dut_dones;
        cyc(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(4, 0)));
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, bit'(i & 1));
            chk($sformatf("gap_done_%0d", i), int'(bus.done), (i == 7) ? 1 : 0);
        end
        idle(3);
        chk("gap_dones",  dut_dones - d0,   1);
        chk("gap_data_o", int'(bus.data_o), 8'hAA);

        // Synchronous clear mid-frame.
        d0 = dut_dones;
        cyc(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("clr_pre_cnt", int'(bus.bit_cnt), 3);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("clr_data_o",  int'(bus.data_o),  0);
        chk("clr_busy",    int'(bus.busy),    0);
        chk("clr_bit_cnt", int'(bus.bit_cnt), 0);
        repeat (8) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("clr_dones", dut_dones - d0, 0);

        // Asynchronous reset mid-frame, between clock edges.
        d0 = dut_dones;
        cyc(1'b0, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("rst_pre_cnt", int'(bus.bit_cnt), 3);
        #1 rst = 1'b1;
        #1;
        chk("arst_data_o",   int'(bus.data_o),   0);
        chk("arst_serial_o", int'(bus.serial_o), 0);
        chk("arst_bit_cnt",  int'(bus.bit_cnt),  0);
        chk("arst_busy",     int'(bus.busy),     0);
        chk("arst_done",     int'(bus.done),     0);
        model_reset();
        #1 rst = 1'b0;
        repeat (8) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("arst_dones", dut_dones - d0, 0);

        // Back-to-back frames: load during the done cycle.
        cyc(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, rx_msb[i]);
        chk("b2b_first_done", int'(bus.done),   1);
        chk("b2b_first_data", int'(bus.data_o), 8'hCA);
        cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("b2b_busy",   int'(bus.busy),   1);
        chk("b2b_done",   int'(bus.done),   0);
        chk("b2b_loaded", int'(bus.data_o), 8'h3C);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, rx_lsb[i]);
        chk("b2b_second_done", int'(bus.done),   1);
        chk("b2b_second_data", int'(bus.data_o), 8'h01);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
